// File: rtl/uart_rx_param_if.sv
// Receive-side output bundle of uart_rx_param: frame strobe, received word,
// error flags and busy indication.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_rx_valid;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_break, o_busy
  );

  modport slave (
    input o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: input synchroniser, 3-sample majority voting per bit,
// optional parity, 1 or 2 stop bits, parity/framing/break reporting.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rx_serial,
  uart_rx_param_if.master rx_if
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] SMP0_C = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP1_C = CW'(HALF);
  localparam logic [CW-1:0] SMP2_C = CW'(HALF + 1);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 rx_s;
  logic [CW-1:0]        cnt_r;
  logic [3:0]           bit_cnt_r;
  logic                 s0_r, s1_r;
  logic                 maj_s, decide_s, par_exp_s, last_data_s, last_stop_s, done_s;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_pend_r, ferr_pend_r, zero_pend_r;
  logic                 valid_r, perr_r, ferr_r, brk_r, busy_r;
  logic [DATA_BITS-1:0] data_r;

  assign rx_s        = sync_r[SYNC_STAGES-1];
  assign decide_s    = (cnt_r == SMP2_C);
  assign maj_s       = (s0_r & s1_r) | (s0_r & rx_s) | (s1_r & rx_s);
  assign par_exp_s   = (PARITY_MODE == 1) ? ~^shift_r : ^shift_r;
  assign last_data_s = (bit_cnt_r == 4'(DATA_BITS - 1));
  assign last_stop_s = (bit_cnt_r == 4'(STOP_BITS - 1));

  assign rx_if.o_rx_valid   = valid_r;
  assign rx_if.o_rx_data    = data_r;
  assign rx_if.o_parity_err = perr_r;
  assign rx_if.o_frame_err  = ferr_r;
  assign rx_if.o_break      = brk_r;
  assign rx_if.o_busy       = busy_r;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; done_s marks the final stop-bit decision of a frame.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rx_s) state_s = S_START;
        else       state_s = S_IDLE;
      end
      S_START: begin
        if (decide_s && maj_s) state_s = S_IDLE;
        else if (decide_s)     state_s = S_DATA;
        else                   state_s = S_START;
      end
      S_DATA: begin
        if (decide_s && last_data_s) state_s = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        else                         state_s = S_DATA;
      end
      S_PARITY: begin
        if (decide_s) state_s = S_STOP;
        else          state_s = S_PARITY;
      end
      S_STOP: begin
        if (decide_s && last_stop_s) begin
          done_s  = 1'b1;
          // A low stop bit must see the line return high before the next start.
          state_s = (ferr_pend_r || !maj_s) ? S_WAIT_HIGH : S_IDLE;
        end else begin
          state_s = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_s = S_IDLE;
        else      state_s = S_WAIT_HIGH;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath: synchroniser, bit-period counter, vote samples, shift register, flags, outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_r      <= '1;
      cnt_r       <= '0;
      bit_cnt_r   <= 4'd0;
      s0_r        <= 1'b1;
      s1_r        <= 1'b1;
      shift_r     <= '0;
      perr_pend_r <= 1'b0;
      ferr_pend_r <= 1'b0;
      zero_pend_r <= 1'b1;
      valid_r     <= 1'b0;
      data_r      <= '0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      brk_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], i_rx_serial};
      valid_r <= done_s;
      busy_r  <= (state_s != S_IDLE);
      // Counter starts at the start edge and wraps on bit boundaries from then on.
      if (state_r == S_IDLE || cnt_r == LAST_C) cnt_r <= '0;
      else                                      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == SMP0_C) s0_r <= rx_s;
      if (cnt_r == SMP1_C) s1_r <= rx_s;
      case (state_r)
        S_IDLE: begin
          bit_cnt_r   <= 4'd0;
          perr_pend_r <= 1'b0;
          ferr_pend_r <= 1'b0;
          zero_pend_r <= 1'b1;
        end
        S_DATA: if (decide_s) begin
          shift_r     <= {maj_s, shift_r[DATA_BITS-1:1]};
          zero_pend_r <= zero_pend_r & ~maj_s;
          bit_cnt_r   <= last_data_s ? 4'd0 : bit_cnt_r + 4'd1;
        end
        S_PARITY: if (decide_s) begin
          perr_pend_r <= (maj_s != par_exp_s);
          zero_pend_r <= zero_pend_r & ~maj_s;
        end
        S_STOP: if (decide_s) begin
          ferr_pend_r <= ferr_pend_r | ~maj_s;
          zero_pend_r <= zero_pend_r & ~maj_s;
          bit_cnt_r   <= bit_cnt_r + 4'd1;
        end
        default: ;
      endcase
      if (done_s) begin
        data_r <= shift_r;
        perr_r <= perr_pend_r;
        ferr_r <= ferr_pend_r | ~maj_s;
        brk_r  <= zero_pend_r & ~maj_s;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 8E1, 9O2) at
// 16 clocks per bit, one shared stimulus line steered to the selected receiver.
module tb_uart_rx_param;
  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  int   sel = 0;
  logic rx_a, rx_b, rx_c;
  int   cyc = 0;
  int   t_start = 0;
  int   last_valid_a = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$], qb[$], qc[$];

  assign rx_a = (sel == 0) ? line : 1'b1;
  assign rx_b = (sel == 1) ? line : 1'b1;
  assign rx_c = (sel == 2) ? line : 1'b1;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(9)) if_c ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_a (.i_clk(clk), .i_rst(rst), .i_rx_serial(rx_a), .rx_if(if_a.master));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_b (.i_clk(clk), .i_rst(rst), .i_rx_serial(rx_b), .rx_if(if_b.master));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2), .SYNC_STAGES(2))
    dut_c (.i_clk(clk), .i_rst(rst), .i_rx_serial(rx_c), .rx_if(if_c.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop/compare on each frame strobe.
  always @(negedge clk) begin
    exp_t e;
    if (if_a.o_rx_valid) begin
      last_valid_a = cyc;
      chk("A_valid_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("A_data", 32'(if_a.o_rx_data), 32'(e.data));
        chk("A_parity_err", 32'(if_a.o_parity_err), 32'(e.pe));
        chk("A_frame_err", 32'(if_a.o_frame_err), 32'(e.fe));
        chk("A_break", 32'(if_a.o_break), 32'(e.brk));
      end
    end
    if (if_b.o_rx_valid) begin
      chk("B_valid_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("B_data", 32'(if_b.o_rx_data), 32'(e.data));
        chk("B_parity_err", 32'(if_b.o_parity_err), 32'(e.pe));
        chk("B_frame_err", 32'(if_b.o_frame_err), 32'(e.fe));
        chk("B_break", 32'(if_b.o_break), 32'(e.brk));
      end
    end
    if (if_c.o_rx_valid) begin
      chk("C_valid_expected", 32'(qc.size() != 0), 32'd1);
      if (qc.size() != 0) begin
        e = qc.pop_front();
        chk("C_data", 32'(if_c.o_rx_data), 32'(e.data));
        chk("C_parity_err", 32'(if_c.o_parity_err), 32'(e.pe));
        chk("C_frame_err", 32'(if_c.o_frame_err), 32'(e.fe));
        chk("C_break", 32'(if_c.o_break), 32'(e.brk));
      end
    end
  end

  // Drive one frame (start, data LSB first, optional parity, stops) on receiver `which`,
  // optionally inverting frame bit `glitch` for a single clock mid-bit, then idle high.
  task automatic send(input int which, input logic [8:0] d, input int nd, input int pbit,
                      input logic [1:0] stops, input int ns, input int glitch);
    logic [15:0] f;
    int n;
    f    = '1;
    f[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < nd; i++) begin
      f[n] = d[i];
      n++;
    end
    if (pbit >= 0) begin
      f[n] = pbit[0];
      n++;
    end
    for (int s = 0; s < ns; s++) begin
      f[n] = stops[s];
      n++;
    end
    sel = which;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        line = (i == glitch && c == 9) ? ~f[i] : f[i];
        if (i == 0 && c == 0) t_start = cyc + 1;
        @(negedge clk);
      end
    end
    line = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_A_drained"}, 32'(qa.size()), 32'd0);
    chk({tag, "_B_drained"}, 32'(qb.size()), 32'd0);
    chk({tag, "_C_drained"}, 32'(qc.size()), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 32'(if_a.o_rx_valid), 32'd0);
    chk({tag, "_data"}, 32'(if_a.o_rx_data), 32'd0);
    chk({tag, "_parity_err"}, 32'(if_a.o_parity_err), 32'd0);
    chk({tag, "_frame_err"}, 32'(if_a.o_frame_err), 32'd0);
    chk({tag, "_break"}, 32'(if_a.o_break), 32'd0);
    chk({tag, "_busy"}, 32'(if_a.o_busy), 32'd0);
  endtask

  initial begin
    int lat;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");
    repeat (4) @(negedge clk);

    // Clean 8N1 frame plus strobe latency from the first clock edge seeing the start bit.
    qa.push_back('{data: 9'h0A5, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(0, 9'h0A5, 8, -1, 2'b11, 1, -1);
    lat = last_valid_a - t_start;
    chk($sformatf("A_latency_%0d_in_154_156", lat), 32'(lat >= 154 && lat <= 156), 32'd1);
    drained("clean");

    // Three-clock low glitch on an idle line: false start, no frame.
    sel  = 0;
    line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    chk("glitch_busy_rise", 32'(if_a.o_busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (if_a.o_busy) @(negedge clk);
    end
    chk("glitch_busy_drop", 32'(if_a.o_busy), 32'd0);
    repeat (32) @(negedge clk);
    drained("false_start");

    // Single-clock inversion at the middle of data bit 3 is outvoted.
    qa.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(0, 9'h000, 8, -1, 2'b11, 1, 4);
    drained("vote");

    // Low stop bit: framing error, data still delivered, not a break.
    qa.push_back('{data: 9'h05A, pe: 1'b0, fe: 1'b1, brk: 1'b0});
    send(0, 9'h05A, 8, -1, 2'b00, 1, -1);
    drained("framing");

    // Line held low for 20 bit times: exactly one break frame.
    qa.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b1, brk: 1'b1});
    line = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    drained("break");
    qa.push_back('{data: 9'h03C, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(0, 9'h03C, 8, -1, 2'b11, 1, -1);
    drained("after_break");

    // Reset in the middle of data bit 4 of an 0xFF frame aborts it.
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    line = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midframe_reset");
    rst = 1'b0;
    repeat (32) @(negedge clk);
    drained("midframe_reset");
    qa.push_back('{data: 9'h0C3, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(0, 9'h0C3, 8, -1, 2'b11, 1, -1);
    drained("after_reset");

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    qb.push_back('{data: 9'h007, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(1, 9'h007, 8, 1, 2'b11, 1, -1);
    qb.push_back('{data: 9'h007, pe: 1'b1, fe: 1'b0, brk: 1'b0});
    send(1, 9'h007, 8, 0, 2'b11, 1, -1);
    drained("parity");

    // 9 data bits, odd parity, two stops: 0x1FF has nine ones, correct parity bit is 0.
    qc.push_back('{data: 9'h1FF, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send(2, 9'h1FF, 9, 0, 2'b11, 2, -1);
    qc.push_back('{data: 9'h1FF, pe: 1'b0, fe: 1'b1, brk: 1'b0});
    send(2, 9'h1FF, 9, 0, 2'b01, 2, -1);
    drained("sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
